pipe_sub32: RTL and testbench

- 4-stage pipelined 32-bit subtract/compare unit; the subtract-direction counterpart of the pipelined CLA adder in the myCPU execute datapath.
- Computes A - B (SUB/CMP) or A - B - !C (SBC) in 8-bit slices, one slice per stage.
- Produces ARM-style NZCV flags and carries a destination tag.
- Uses a valid/ready handshake with backpressure and a flush input for branch-mispredict squash.

---
 rtl/pipe_sub32_if.sv | 25 ++
 rtl/pipe_sub32.sv | 86 ++++++++
 tb/tb_pipe_sub32.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_sub32_if.sv
// pipe_sub32_if: operand/result handshake bundle for the pipelined subtractor
interface pipe_sub32_if #(parameter int TAG_W = 5);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic             in_cin;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_res;
  logic [TAG_W-1:0] out_tag;
  logic             out_n;
  logic             out_z;
  logic             out_c;
  logic             out_v;
  modport master (
    output in_valid, in_a, in_b, in_cin, in_tag, out_ready,
    input  in_ready, out_valid, out_res, out_tag, out_n, out_z, out_c, out_v
  );
  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_tag, out_ready,
    output in_ready, out_valid, out_res, out_tag, out_n, out_z, out_c, out_v
  );
endinterface

// File: rtl/pipe_sub32.sv
// pipe_sub32: 4-stage 32-bit subtract/compare (a + ~b + cin), one 8-bit slice per stage, NZCV flags
module pipe_sub32 #(
  parameter int TAG_W   = 5,
  parameter int SLICE_W = 8
) (
  input logic        clk,
  input logic        rst,
  input logic        flush,
  pipe_sub32_if.slave bus
);
  localparam int S = SLICE_W;
  if (S != 8) begin : g_bad_slice
    $error("pipe_sub32: SLICE_W must be 8");
  end
  function automatic logic [S:0] slice_sub(input logic [S-1:0] a, input logic [S-1:0] b, input logic c);
    return {1'b0, a} + {1'b0, ~b} + {{S{1'b0}}, c};
  endfunction
  logic             stall;
  logic             v1, v2, v3, v4;
  logic             c1, c2, c3, c4;
  logic             z1, z2, z3, z4;
  logic             o4;
  logic [31:S]      a1, b1;
  logic [31:2*S]    a2, b2;
  logic [31:3*S]    a3, b3;
  logic [S-1:0]     r1;
  logic [2*S-1:0]   r2;
  logic [3*S-1:0]   r3;
  logic [31:0]      r4;
  logic [TAG_W-1:0] t1, t2, t3, t4;
  logic [S:0]       x1, x2, x3, x4;
  assign x1 = slice_sub(bus.in_a[S-1:0], bus.in_b[S-1:0], bus.in_cin);
  assign x2 = slice_sub(a1[2*S-1:S], b1[2*S-1:S], c1);
  assign x3 = slice_sub(a2[3*S-1:2*S], b2[3*S-1:2*S], c2);
  assign x4 = slice_sub(a3[31:3*S], b3[31:3*S], c3);
  assign stall        = v4 & ~bus.out_ready;
  assign bus.in_ready = ~rst & ~flush & ~stall;
  assign bus.out_valid = v4;
  assign bus.out_res   = r4;
  assign bus.out_tag   = t4;
  assign bus.out_n     = r4[31];
  assign bus.out_z     = z4;
  assign bus.out_c     = c4;
  assign bus.out_v     = o4;
  // flush only kills valid bits; stale data behind a cleared valid is harmless
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {v1, v2, v3, v4} <= '0;
      {c1, c2, c3, c4} <= '0;
      {z1, z2, z3, z4, o4} <= '0;
      {a1, b1, a2, b2, a3, b3} <= '0;
      {r1, r2, r3, r4} <= '0;
      {t1, t2, t3, t4} <= '0;
    end else if (flush) begin
      {v1, v2, v3, v4} <= '0;
    end else if (!stall) begin
      v1 <= bus.in_valid;
      a1 <= bus.in_a[31:S];
      b1 <= bus.in_b[31:S];
      r1 <= x1[S-1:0];
      c1 <= x1[S];
      z1 <= x1[S-1:0] == '0;
      t1 <= bus.in_tag;
      v2 <= v1;
      a2 <= a1[31:2*S];
      b2 <= b1[31:2*S];
      r2 <= {x2[S-1:0], r1};
      c2 <= x2[S];
      z2 <= z1 & (x2[S-1:0] == '0);
      t2 <= t1;
      v3 <= v2;
      a3 <= a2[31:3*S];
      b3 <= b2[31:3*S];
      r3 <= {x3[S-1:0], r2};
      c3 <= x3[S];
      z3 <= z2 & (x3[S-1:0] == '0);
      t3 <= t2;
      v4 <= v3;
      r4 <= {x4[S-1:0], r3};
      c4 <= x4[S];
      z4 <= z3 & (x4[S-1:0] == '0);
      o4 <= x4[S] ^ (a3[31] ^ ~b3[31] ^ x4[S-1]);
      t4 <= t3;
    end
  end
endmodule

// File: tb/tb_pipe_sub32.sv
// tb_pipe_sub32: directed vectors plus a queue-based reference model checked every cycle
module tb_pipe_sub32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  pipe_sub32_if #(.TAG_W(5)) bus ();
  pipe_sub32 #(.TAG_W(5), .SLICE_W(8)) dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus));
  typedef struct {
    logic [31:0] res;
    logic [3:0]  f;
    logic [4:0]  tag;
    int          age;
  } exp_t;
  typedef struct {
    logic [4:0] tag;
    int         cyc;
  } log_t;
  exp_t q[$];
  log_t lg[$];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // signed overflow stated as "operands of like sign give a result of the other sign"
  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic [4:0] t);
    exp_t e;
    logic [32:0] s;
    logic nb;
    s = {1'b0, a} + {1'b0, ~b} + {32'd0, cin};
    nb = ~b[31];
    e.res = s[31:0];
    e.f = {s[31], s[31:0] == 32'd0, s[32], (a[31] == nb) && (s[31] != a[31])};
    e.tag = t;
    e.age = 0;
    return e;
  endfunction
  always @(negedge clk) begin
    logic ev, stl;
    cyc++;
    if (rst) begin
      q.delete();
    end else begin
      ev = q.size() > 0 && q[0].age >= 3;
      stl = ev && !bus.out_ready;
      chk("out_valid", bus.out_valid, ev);
      chk("in_ready", bus.in_ready, !flush && !stl);
      if (ev) begin
        chk("out_res", bus.out_res, q[0].res);
        chk("out_nzcv", {bus.out_n, bus.out_z, bus.out_c, bus.out_v}, q[0].f);
        chk("out_tag", bus.out_tag, q[0].tag);
        if (bus.out_ready) begin
          lg.push_back('{q[0].tag, cyc});
          void'(q.pop_front());
        end
      end
      if (flush) q.delete();
      else if (!stl) begin
        foreach (q[j]) q[j].age++;
        if (bus.in_valid) q.push_back(mk(bus.in_a, bus.in_b, bus.in_cin, bus.in_tag));
      end
    end
  end
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic [4:0] t);
    int k = 0;
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_cin = cin;
    bus.in_tag = t;
    @(negedge clk);
    while (!bus.in_ready && k < 50) begin
      k++;
      @(negedge clk);
    end
    if (k >= 50) chk("send_timeout", 1, 0);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask
  task automatic one(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic [4:0] t,
                     input logic [31:0] eres, input logic [3:0] ef);
    send(a, b, cin, t);
    repeat (3) @(negedge clk);
    chk("lat_early", bus.out_valid, 0);
    @(negedge clk);
    chk("lat_valid", bus.out_valid, 1);
    chk("lit_res", bus.out_res, eres);
    chk("lit_nzcv", {bus.out_n, bus.out_z, bus.out_c, bus.out_v}, ef);
    chk("lit_tag", bus.out_tag, t);
    @(posedge clk);
    #1;
  endtask
  task automatic wait_valid();
    int k = 0;
    @(negedge clk);
    while (!bus.out_valid && k < 20) begin
      k++;
      @(negedge clk);
    end
    if (k >= 20) chk("wait_valid_timeout", 1, 0);
  endtask
  initial begin
    int lb;
    logic [31:0] ta[8] = '{32'h0000_0010, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000,
                           32'h7FFF_FFFF, 32'h1234_5678, 32'h00FF_FF00, 32'hDEAD_BEEF};
    logic [31:0] tb[8] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000,
                           32'hFFFF_FFFF, 32'h8765_4321, 32'h0000_0100, 32'hBEEF_DEAD};
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_cin = 1'b0;
    bus.in_tag = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_res", bus.out_res, 0);
    chk("rst_tag", bus.out_tag, 0);
    chk("rst_nzcv", {bus.out_n, bus.out_z, bus.out_c, bus.out_v}, 0);
    chk("rst_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    one(32'h5, 32'h3, 1'b1, 5'd7, 32'h2, 4'b0010);
    one(32'h1234_5678, 32'h1234_5678, 1'b1, 5'd1, 32'h0, 4'b0110);
    one(32'h0, 32'h1, 1'b1, 5'd2, 32'hFFFF_FFFF, 4'b1000);
    one(32'h8000_0000, 32'h1, 1'b1, 5'd3, 32'h7FFF_FFFF, 4'b0011);
    one(32'h5, 32'h3, 1'b0, 5'd4, 32'h1, 4'b0010);
    lb = lg.size();
    for (int j = 0; j < 8; j++) send(ta[j], tb[j], j[0], 5'(j));
    repeat (8) @(negedge clk);
    chk("b2b_count", lg.size() - lb, 8);
    for (int j = 0; j < 8 && lb + j < lg.size(); j++) begin
      chk("b2b_tag", lg[lb+j].tag, 5'(j));
      chk("b2b_cycle", lg[lb+j].cyc - lg[lb].cyc, j);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    lb = lg.size();
    send(32'h100, 32'h1, 1'b1, 5'd10);
    send(32'h200, 32'h2, 1'b1, 5'd11);
    send(32'h300, 32'h3, 1'b1, 5'd12);
    wait_valid();
    repeat (3) begin
      chk("stall_ready", bus.in_ready, 0);
      chk("stall_tag", bus.out_tag, 10);
      chk("stall_res", bus.out_res, 32'hFF);
      @(negedge clk);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("stall_count", lg.size() - lb, 3);
    for (int j = 0; j < 3 && lb + j < lg.size(); j++) begin
      chk("stall_order", lg[lb+j].tag, 5'(10 + j));
      chk("stall_cycle", lg[lb+j].cyc - lg[lb].cyc, j);
    end
    @(posedge clk);
    #1;
    send(32'h20, 32'h1, 1'b1, 5'd20);
    send(32'h21, 32'h1, 1'b1, 5'd21);
    send(32'h22, 32'h1, 1'b1, 5'd22);
    bus.in_valid = 1'b1;
    bus.in_tag = 5'd23;
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    bus.in_valid = 1'b0;
    lb = lg.size();
    repeat (8) @(negedge clk);
    chk("flush_drop", lg.size() - lb, 0);
    @(posedge clk);
    #1;
    one(32'hFFFF_0000, 32'h0001_0000, 1'b1, 5'd24, 32'hFFFE_0000, 4'b1010);
    bus.out_ready = 1'b0;
    send(32'h7, 32'h1, 1'b1, 5'd25);
    send(32'h8, 32'h1, 1'b1, 5'd26);
    wait_valid();
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid", bus.out_valid, 0);
    chk("rst_async_res", bus.out_res, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    bus.out_ready = 1'b1;
    lb = lg.size();
    repeat (6) @(negedge clk);
    chk("rst_drop", lg.size() - lb, 0);
    @(posedge clk);
    #1;
    one(32'h0000_0100, 32'h0000_0001, 1'b1, 5'd27, 32'h0000_00FF, 4'b0010);
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
